// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue
//
// Word-level transfer queue that feeds an SPI master. Host words are buffered
// in a TX FIFO. One SPI transfer is launched per word through the master's
// m_start/m_data_in pair. Each received word is captured into an RX FIFO on
// the master's m_finish pulse. Transfers run back-to-back while TX holds data
// and RX has room. Only one transfer is in flight at a time, and RX space is
// reserved at launch, so RX can never overflow.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   tx_valid/tx_data/tx_ready      host push into the TX FIFO
//   rx_valid/rx_data/rx_ready      host pop from the RX FIFO (rx_data is the
//                                  combinational head, zero when empty)
//   tx_count, rx_count             FIFO occupancies
//   busy                           FSM is not in IDLE
//   m_start, m_data_in             start pulse and registered word to the master
//   m_spi_ready                    master is idle
//   m_finish, m_data_out           master finish pulse and received word
//
// Optional feature macro: SPI_XFER_GAP_EN
//   When defined, a GAP state inserts GAP_CYCLES idle clocks after every
//   transfer (CS-high deselect time). When undefined, GAP_CYCLES is unused.

module spi_xfer_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_valid,
  input  logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_ready,
  output logic                     rx_valid,
  output logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     busy,
  output logic                     m_start,
  output logic [DATA_WIDTH-1:0]    m_data_in,
  input  logic                     m_spi_ready,
  input  logic                     m_finish,
  input  logic [DATA_WIDTH-1:0]    m_data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef SPI_XFER_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
`ifdef SPI_XFER_GAP_EN
    GAP      = 2'd3,
`endif
    WAIT_FIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] txMem [DEPTH];
  logic [DATA_WIDTH-1:0] rxMem [DEPTH];
  logic [AW-1:0]         txWrPtr_q, txRdPtr_q, rxWrPtr_q, rxRdPtr_q;
  logic [CW-1:0]         txCount_q, rxCount_q;
  logic [DATA_WIDTH-1:0] mDataIn_q;

`ifdef SPI_XFER_GAP_EN
  logic [GW-1:0]         gapCnt_q, gapCnt_d;
`endif

  logic txPush, txPop, rxPush, rxPop;

  // Handshake flags come only from registered counts, so tx_ready and
  // rx_valid have no combinational path from any input.
  assign tx_ready = (txCount_q != FULL);
  assign rx_valid = (rxCount_q != '0);
  assign rx_data  = rx_valid ? rxMem[rxRdPtr_q] : '0;
  assign tx_count = txCount_q;
  assign rx_count = rxCount_q;
  assign busy     = (state_q != IDLE);
  assign m_start  = (state_q == LAUNCH);
  assign m_data_in = mDataIn_q;

  assign txPush = tx_valid & tx_ready;
  assign rxPop  = rx_valid & rx_ready;

  // Next-state logic. A launch needs a TX word, a free RX slot (the slot is
  // reserved for this transfer's reply) and an idle master. The TX head is
  // popped on the same cycle the FSM leaves IDLE.
  always_comb begin
    state_d = state_q;
    txPop   = 1'b0;
    rxPush  = 1'b0;
`ifdef SPI_XFER_GAP_EN
    gapCnt_d = gapCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (txCount_q != '0 && rxCount_q < FULL && m_spi_ready) begin
          txPop   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (m_finish) begin
          rxPush = 1'b1;
`ifdef SPI_XFER_GAP_EN
          gapCnt_d = '0;
          state_d  = GAP;
`else
          state_d  = IDLE;
`endif
        end
      end
`ifdef SPI_XFER_GAP_EN
      GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + GW'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointers, counts and the launch word register. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      rxWrPtr_q <= '0;
      rxRdPtr_q <= '0;
      txCount_q <= '0;
      rxCount_q <= '0;
      mDataIn_q <= '0;
`ifdef SPI_XFER_GAP_EN
      gapCnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SPI_XFER_GAP_EN
      gapCnt_q <= gapCnt_d;
`endif
      if (txPush) txWrPtr_q <= txWrPtr_q + AW'(1);
      if (txPop) begin
        txRdPtr_q <= txRdPtr_q + AW'(1);
        mDataIn_q <= txMem[txRdPtr_q];
      end
      if (rxPush) rxWrPtr_q <= rxWrPtr_q + AW'(1);
      if (rxPop)  rxRdPtr_q <= rxRdPtr_q + AW'(1);
      case ({txPush, txPop})
        2'b10:   txCount_q <= txCount_q + CW'(1);
        2'b01:   txCount_q <= txCount_q - CW'(1);
        default: txCount_q <= txCount_q;
      endcase
      case ({rxPush, rxPop})
        2'b10:   rxCount_q <= rxCount_q + CW'(1);
        2'b01:   rxCount_q <= rxCount_q - CW'(1);
        default: rxCount_q <= rxCount_q;
      endcase
    end
  end

  // Storage arrays carry no reset; stale entries are never visible because
  // reads are qualified by the counts.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr_q] <= tx_data;
    if (rxPush) rxMem[rxWrPtr_q] <= m_data_out;
  end

endmodule
